timer_clk_gate_ctrl: RTL and testbench
======================================

Name: timer_clk_gate_ctrl

Overview:
Per-channel clock-gate enable controller for the advanced timer. Generates the en_i of each channel's tc_clk_gating cell. Channels request their clock through a req/ack handshake, and the controller keeps the clock on while the channel is busy. After a programmable idle time it gates the clock off. Sits between the timer register file / channel logic and the gating cells.

Parameters:
N_CH, 4, number of timer channels controlled
WAKE_CYC, 2, cycles clock runs after enable before ack is given (settle time); legal range 1..255
IDLE_CYC, 8, idle cycles with clock still on before gating off; legal range 0..255
CNT_W, 8, width of each channel's internal down-counter

Ports:
clk_i  input  1  free-running (ungated) clock
rstn_i  input  1  asynchronous active-low reset
bypass_i  input  1  global gating bypass from config register; 1 = every channel treated as force-on
force_on_i  input  N_CH  per-channel software keep-on
req_i  input  N_CH  channel requests clock; held until ack and for as long as the clock is needed
busy_i  input  N_CH  channel activity (counter running, compare pending)
ack_o  output  N_CH  clock guaranteed stable for channel
clk_en_o  output  N_CH  to tc_clk_gating en_i
gated_o  output  N_CH  status: channel clock is off
all_gated_o  output  1  AND of gated_o

Behaviour:
- Per channel, wake condition w = req_i | busy_i | force_on_i | bypass_i.
- Reset (async, any time including mid-sequence): every channel goes to OFF, counter = 0. Outputs: clk_en_o=0, ack_o=0, gated_o=1, all_gated_o=1. All outputs take these values immediately on reset assertion.
- FSM states: OFF, WAKE, ON, COOL.
- OFF: clk_en_o=0, gated_o=1. If w is true, go to WAKE and load counter with WAKE_CYC.
- WAKE:
  - clk_en_o=1.
  - If counter==1, go to ON; otherwise decrement the counter.
  - WAKE lasts exactly WAKE_CYC cycles.
  - A dropped req_i does not abort the sequence; WAKE always completes to ON.
- ON:
  - clk_en_o=1; ack_o = req_i (combinational from the state register).
  - If !w, go to COOL and load counter with IDLE_CYC.
  - If IDLE_CYC==0 and !w, go directly to OFF.
- COOL:
  - clk_en_o=1, ack_o=0.
  - If w is true, go back to ON; ack reasserts the cycle after.
  - Else if counter==1, go to OFF; otherwise decrement.
  - COOL lasts IDLE_CYC cycles.
- Latency:
  - req first sampled high in OFF at cycle t: clk_en_o=1 from t+1, ack_o=1 from t+1+WAKE_CYC.
  - Last cycle with w high in ON at cycle t: clk_en_o=0 from t+2+IDLE_CYC.
- clk_en_o and gated_o are decoded from the state register only (glitch-free, no input-to-output path). ack_o is the only output combinational on an input.
- Channels are fully independent. No arbitration is needed because each channel owns its own gate.
- Simultaneous events:
  - w rising in the same cycle the COOL counter hits 1: w wins, next state is ON.
  - bypass_i deasserting: channels go ON→COOL→OFF normally; there is no abrupt cut.
- Counter never underflows; it is only decremented when greater than 1.

Decomposition:
- Package timer_cg_pkg:
  - cg_state_e enum, 2 bits: CG_OFF=0, CG_WAKE=1, CG_ON=2, CG_COOL=3.
  - Counter width constant CG_CNT_W=8.
- Sub-module timer_cg_ch_fsm: one channel's FSM and counter, with scalar ports.
- Top instantiates N_CH copies in a generate loop and computes all_gated_o.

Test Plan:
1. Reset then idle. Hold rstn_i=0 for 3 cycles, release, all inputs 0 for 20 cycles → clk_en_o=0, ack_o=0, gated_o=4'hF, all_gated_o=1 throughout.
2. Basic wake/gate with WAKE_CYC=2, IDLE_CYC=8. req_i[0]=1 at cycle 10:
   - clk_en_o[0]=1 at 11, ack_o[0]=1 at 13.
   - Drop req at 20 → ack_o[0]=0 at 20, clk_en_o[0]=0 at 29.
   - Other channels stay gated.
3. Re-wake in COOL. Drop req_i[1], then reassert busy_i[1] on the 5th COOL cycle → clk_en_o[1] never falls and the state returns to ON. Reassert req → ack the next cycle with no WAKE delay.
4. Reset mid-WAKE. rstn_i=0 one cycle after req_i[2] rises → clk_en_o[2]=0 asynchronously. After release with req still high, a full WAKE_CYC sequence repeats before ack.
5. Bypass and force. bypass_i=1 → all clk_en_o=1 after 1 cycle, all_gated_o=0. force_on_i[3]=1 holds channel 3 on after bypass drops; channels 0–2 gate off IDLE_CYC+1 cycles later.
6. IDLE_CYC=0 and WAKE_CYC=1 build. Single-cycle req pulse → clk_en_o high for exactly 2 cycles and ack_o stays 0. Held req → ack 2 cycles after req.

Source files
------------

// File: rtl/timer_cg_pkg.sv
// Shared types for the timer clock-gate controller: channel FSM states and counter width.
package timer_cg_pkg;

   typedef enum logic [1:0] {
      CG_OFF  = 2'd0,
      CG_WAKE = 2'd1,
      CG_ON   = 2'd2,
      CG_COOL = 2'd3
   } cg_state_e;

   localparam int CG_CNT_W = 8;

endpackage

// File: rtl/timer_cg_ch_fsm.sv
// One channel's gate FSM: OFF -> WAKE (WAKE_CYC cycles) -> ON -> COOL (IDLE_CYC cycles) -> OFF.
// clk_en_o/gated_o decode the state register only; ack_o is the single input-to-output path.
module timer_cg_ch_fsm
   import timer_cg_pkg::*;
#(
   parameter int WAKE_CYC = 2,
   parameter int IDLE_CYC = 8,
   parameter int CNT_W    = CG_CNT_W
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic wake_i,
   input  logic req_i,
   output logic ack_o,
   output logic clk_en_o,
   output logic gated_o
);

   cg_state_e        r_state;
   cg_state_e        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_cnt_last;

   assign w_cnt_last = (r_cnt <= CNT_W'(1));

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= CG_OFF;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         CG_OFF: begin
            if (wake_i) begin
               w_state_nxt = CG_WAKE;
               w_cnt_nxt   = CNT_W'(WAKE_CYC);
            end
         end
         // A dropped request never aborts the settle period.
         CG_WAKE: begin
            if (w_cnt_last) w_state_nxt = CG_ON;
            else            w_cnt_nxt   = r_cnt - CNT_W'(1);
         end
         CG_ON: begin
            if (!wake_i) begin
               if (IDLE_CYC == 0) begin
                  w_state_nxt = CG_OFF;
               end else begin
                  w_state_nxt = CG_COOL;
                  w_cnt_nxt   = CNT_W'(IDLE_CYC);
               end
            end
         end
         CG_COOL: begin
            if (wake_i)          w_state_nxt = CG_ON;
            else if (w_cnt_last) w_state_nxt = CG_OFF;
            else                 w_cnt_nxt   = r_cnt - CNT_W'(1);
         end
         default: w_state_nxt = CG_OFF;
      endcase
   end

   assign clk_en_o = (r_state != CG_OFF);
   assign gated_o  = (r_state == CG_OFF);
   assign ack_o    = (r_state == CG_ON) & req_i;

endmodule

// File: rtl/timer_clk_gate_ctrl.sv
// Per-channel clock-gate enable controller; one independent FSM per timer channel.
// clk_en rises 1 cycle after wake, ack follows WAKE_CYC later, gate-off IDLE_CYC+2 after last wake.
module timer_clk_gate_ctrl
   import timer_cg_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int WAKE_CYC = 2,
   parameter int IDLE_CYC = 8,
   parameter int CNT_W    = CG_CNT_W
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   input  logic            bypass_i,
   input  logic [N_CH-1:0] force_on_i,
   input  logic [N_CH-1:0] req_i,
   input  logic [N_CH-1:0] busy_i,
   output logic [N_CH-1:0] ack_o,
   output logic [N_CH-1:0] clk_en_o,
   output logic [N_CH-1:0] gated_o,
   output logic            all_gated_o
);

   logic [N_CH-1:0] w_wake;

   assign w_wake = req_i | busy_i | force_on_i | {N_CH{bypass_i}};

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      timer_cg_ch_fsm #(
         .WAKE_CYC (WAKE_CYC),
         .IDLE_CYC (IDLE_CYC),
         .CNT_W    (CNT_W)
      ) u_ch (
         .clk_i    (clk_i),
         .rstn_i   (rstn_i),
         .wake_i   (w_wake[g]),
         .req_i    (req_i[g]),
         .ack_o    (ack_o[g]),
         .clk_en_o (clk_en_o[g]),
         .gated_o  (gated_o[g])
      );
   end

   assign all_gated_o = &gated_o;

endmodule

// File: tb/tb_timer_clk_gate_ctrl.sv
// Directed bench for timer_clk_gate_ctrl: default build (WAKE=2, IDLE=8) plus a WAKE=1/IDLE=0 build.
module tb_timer_clk_gate_ctrl;

   logic       clk = 1'b0;
   logic       rstn;
   logic       bypass;
   logic [3:0] force_on, req, busy;
   logic [3:0] ack, clk_en, gated;
   logic       all_gated;

   logic [3:0] req2;
   logic [3:0] ack2, clk_en2, gated2;
   logic       all_gated2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   timer_clk_gate_ctrl #(.N_CH(4), .WAKE_CYC(2), .IDLE_CYC(8), .CNT_W(8)) dut (
      .clk_i(clk), .rstn_i(rstn), .bypass_i(bypass), .force_on_i(force_on),
      .req_i(req), .busy_i(busy), .ack_o(ack), .clk_en_o(clk_en),
      .gated_o(gated), .all_gated_o(all_gated)
   );

   timer_clk_gate_ctrl #(.N_CH(4), .WAKE_CYC(1), .IDLE_CYC(0), .CNT_W(8)) dut2 (
      .clk_i(clk), .rstn_i(rstn), .bypass_i(1'b0), .force_on_i(4'h0),
      .req_i(req2), .busy_i(4'h0), .ack_o(ack2), .clk_en_o(clk_en2),
      .gated_o(gated2), .all_gated_o(all_gated2)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rstn = 1'b0; bypass = 1'b0; force_on = '0; req = '0; busy = '0; req2 = '0;

      // 1. reset then idle
      #1;
      chk("rst_clk_en", clk_en, 8'h0);
      chk("rst_gated", gated, 8'h0F);
      chk("rst_all_gated", all_gated, 8'h1);
      chk("rst_ack", ack, 8'h0);
      step(3);
      rstn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("idle_clk_en", clk_en, 8'h0);
         chk("idle_ack", ack, 8'h0);
         chk("idle_gated", {3'b0, all_gated, gated}, 8'h1F);
      end

      // 2. basic wake / gate on channel 0
      req[0] = 1'b1;
      step();
      chk("t2_wake_clk_en", clk_en, 8'h1);
      chk("t2_wake_ack", ack, 8'h0);
      step();
      chk("t2_wake2_ack", ack, 8'h0);
      step();
      chk("t2_on_ack", ack, 8'h1);
      chk("t2_on_gated", gated, 8'hE);
      step(7);
      req[0] = 1'b0;
      #1;
      chk("t2_drop_ack", ack, 8'h0);
      step(8);
      chk("t2_cool_last_clk_en", clk_en, 8'h1);
      step();
      chk("t2_off_clk_en", clk_en, 8'h0);
      chk("t2_off_all_gated", all_gated, 8'h1);

      // 3. re-wake channel 1 from COOL via busy
      req[1] = 1'b1;
      step(3);
      chk("t3_on_ack", ack, 8'h2);
      req[1] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3_cool_clk_en", clk_en, 8'h2);
      end
      busy[1] = 1'b1;
      step();
      chk("t3_back_on_clk_en", clk_en, 8'h2);
      chk("t3_back_on_ack", ack, 8'h0);
      req[1] = 1'b1;
      #1;
      chk("t3_ack_no_wake", ack, 8'h2);
      step();
      chk("t3_ack_held", ack, 8'h2);
      req[1] = 1'b0; busy[1] = 1'b0;
      step(10);
      chk("t3_gated", gated, 8'hF);

      // 4. reset during WAKE on channel 2
      req[2] = 1'b1;
      step();
      chk("t4_wake_clk_en", clk_en, 8'h4);
      rstn = 1'b0;
      #1;
      chk("t4_async_clk_en", clk_en, 8'h0);
      chk("t4_async_gated", gated, 8'hF);
      step();
      rstn = 1'b1;
      step();
      chk("t4_rewake_clk_en", clk_en, 8'h4);
      chk("t4_rewake_ack", ack, 8'h0);
      step();
      chk("t4_rewake2_ack", ack, 8'h0);
      step();
      chk("t4_on_ack", ack, 8'h4);
      req[2] = 1'b0;
      step(10);
      chk("t4_gated", gated, 8'hF);

      // 5. bypass and force-on
      bypass = 1'b1;
      step();
      chk("t5_bypass_clk_en", clk_en, 8'hF);
      chk("t5_bypass_all_gated", all_gated, 8'h0);
      chk("t5_bypass_ack", ack, 8'h0);
      force_on[3] = 1'b1;
      step(3);
      bypass = 1'b0;
      step(8);
      chk("t5_cool_clk_en", clk_en, 8'hF);
      step();
      chk("t5_forced_clk_en", clk_en, 8'h8);
      chk("t5_forced_all_gated", all_gated, 8'h0);
      force_on[3] = 1'b0;
      step(9);
      chk("t5_all_off", {3'b0, all_gated, gated}, 8'h1F);

      // 6. WAKE_CYC=1, IDLE_CYC=0 build
      req2[0] = 1'b1;
      step();
      chk("t6_pulse_en1", clk_en2, 8'h1);
      chk("t6_pulse_ack1", ack2, 8'h0);
      req2[0] = 1'b0;
      step();
      chk("t6_pulse_en2", clk_en2, 8'h1);
      chk("t6_pulse_ack2", ack2, 8'h0);
      step();
      chk("t6_pulse_off", clk_en2, 8'h0);
      chk("t6_pulse_all_gated", all_gated2, 8'h1);
      req2[0] = 1'b1;
      step();
      chk("t6_held_ack1", ack2, 8'h0);
      step();
      chk("t6_held_ack2", ack2, 8'h1);
      req2[0] = 1'b0;
      #1;
      chk("t6_drop_ack", ack2, 8'h0);
      step();
      chk("t6_drop_off", clk_en2, 8'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
